// File: rtl/spi_frame_reader.sv
// spi_frame_reader
// SCK-domain reader for the ADC frame FIFO. It pops one frame of channel
// words, optionally compacts it to the enabled words, and shifts it out
// MSB-first on MISO. Consecutive frames in a burst are back to back: the next
// frame is prefetched while the second-to-last bit of the current frame is on
// MISO, so the following frame loads on the same edge that retires the last bit.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for CS_N low with STREAM_EN; burst length and mask latched here
// POP   | one-cycle pop request for the first frame of a burst
// LOAD  | FIFO data valid; pack it into shreg and load bit_cnt
// SHIFT | shreg MSB on MISO; one bit per SCK, reload or finish at bit_cnt==1

module spi_frame_reader #(
  parameter int FRAME_WORDS = 8,
  parameter int WORD_W      = 16,
  parameter int CNT_W       = 8
) (
  input  logic                          SCK,
  input  logic                          NRST_sync,
  input  logic                          CS_N,
  input  logic                          STREAM_EN,
  input  logic [CNT_W-1:0]              BURST_LEN,
  input  logic [FRAME_WORDS-1:0]        WORD_MASK,
  input  logic [FRAME_WORDS*WORD_W-1:0] ADC_data,
  output logic                          FIFO_POP,
  output logic                          MISO,
  output logic                          BUSY,
  output logic                          FRAME_DONE,
  output logic                          ABORT,
  output logic [CNT_W-1:0]              FRAME_CNT
);

  localparam int FRAME_BITS = FRAME_WORDS * WORD_W;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        burst_q;
  logic [FRAME_WORDS-1:0]  mask_q;
  logic [FRAME_BITS-1:0]   packed_data;
  logic [BIT_W-1:0]        packed_bits;
  logic                    more;

  // Compact enabled words of the FIFO frame, highest index first, left-aligned.
  // mask_q is never all-zero because the empty mask is widened when latched.
  always_comb begin
    logic [FRAME_BITS-1:0] acc;
    int                    n;
    acc = '0;
    n   = 0;
    for (int i = FRAME_WORDS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        acc = {acc[FRAME_BITS-WORD_W-1:0], ADC_data[i*WORD_W +: WORD_W]};
        n   = n + 1;
      end
    end
    packed_data = acc << ((FRAME_WORDS - n) * WORD_W);
    packed_bits = BIT_W'(n * WORD_W);
  end

  // Another frame follows when the burst is unlimited or not yet exhausted;
  // the compare is one bit wider so FRAME_CNT+1 cannot wrap.
  assign more = (burst_q == '0) ||
                (({1'b0, FRAME_CNT} + (CNT_W+1)'(1)) < {1'b0, burst_q});

  // Pop for the first frame, and prefetch during the second-to-last bit.
  assign FIFO_POP = !CS_N &&
                    ((state == POP) ||
                     ((state == SHIFT) && (bit_cnt == BIT_W'(2)) && more));

  assign MISO = (state == SHIFT) ? shreg[FRAME_BITS-1] : 1'b0;
  assign BUSY = (state != IDLE);

  // Sequencer: CS_N high outside IDLE aborts ahead of any frame completion.
  always_ff @(posedge SCK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      burst_q    <= '0;
      mask_q     <= '1;
      FRAME_CNT  <= '0;
      FRAME_DONE <= 1'b0;
      ABORT      <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      ABORT      <= 1'b0;
      if (CS_N && (state != IDLE)) begin
        state   <= IDLE;
        shreg   <= '0;
        bit_cnt <= '0;
        ABORT   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (!CS_N && STREAM_EN) begin
              state     <= POP;
              FRAME_CNT <= '0;
              burst_q   <= BURST_LEN;
              mask_q    <= (WORD_MASK == '0) ? '1 : WORD_MASK;
            end
          end
          POP: begin
            state <= LOAD;
          end
          LOAD: begin
            shreg   <= packed_data;
            bit_cnt <= packed_bits;
            state   <= SHIFT;
          end
          SHIFT: begin
            if (bit_cnt > BIT_W'(1)) begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - BIT_W'(1);
            end else begin
              FRAME_DONE <= 1'b1;
              FRAME_CNT  <= FRAME_CNT + CNT_W'(1);
              if (more) begin
                shreg   <= packed_data;
                bit_cnt <= packed_bits;
              end else begin
                state   <= IDLE;
                shreg   <= '0;
                bit_cnt <= '0;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_reader.sv
// Testbench for spi_frame_reader: table of directed bursts checked cycle by
// cycle against hand-written expected frames, plus reset sequences.
module tb_spi_frame_reader;

  logic         SCK = 1'b0;
  logic         NRST_sync = 1'b0;
  logic         CS_N = 1'b1;
  logic         STREAM_EN = 1'b0;
  logic [7:0]   BURST_LEN = '0;
  logic [7:0]   WORD_MASK = '0;
  logic [127:0] ADC_data = '0;
  logic         FIFO_POP, MISO, BUSY, FRAME_DONE, ABORT;
  logic [7:0]   FRAME_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] fifo_q[$];
  logic         pop_req = 1'b0;

  spi_frame_reader #(.FRAME_WORDS(8), .WORD_W(16), .CNT_W(8)) dut (
    .SCK(SCK), .NRST_sync(NRST_sync), .CS_N(CS_N), .STREAM_EN(STREAM_EN),
    .BURST_LEN(BURST_LEN), .WORD_MASK(WORD_MASK), .ADC_data(ADC_data),
    .FIFO_POP(FIFO_POP), .MISO(MISO), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .ABORT(ABORT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 SCK = ~SCK;

  // FIFO model: pop seen in the low phase, data presented after the next edge.
  always @(negedge SCK) begin
    #2;
    pop_req = FIFO_POP;
  end
  always @(posedge SCK) begin
    if (pop_req) begin
      if (fifo_q.size() > 0) ADC_data <= fifo_q.pop_front();
      else                   ADC_data <= '0;
    end
  end

  typedef struct {
    logic [7:0]        burst;
    logic [7:0]        mask;
    int                n_fifo;
    logic [2:0][127:0] frm;
    int                bpf;
    int                n_exp;
    logic [2:0][127:0] expf;
    int                abort_c;
    logic [7:0]        exp_cnt;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic [7:0] burst, input logic [7:0] mask,
                              input int n_fifo, input logic [127:0] f0,
                              input logic [127:0] f1, input logic [127:0] f2,
                              input int bpf, input int n_exp,
                              input logic [127:0] e0, input logic [127:0] e1,
                              input logic [127:0] e2, input int abort_c,
                              input logic [7:0] exp_cnt);
    vec_t v;
    v.burst = burst;  v.mask = mask;  v.n_fifo = n_fifo;
    v.frm[0] = f0;  v.frm[1] = f1;  v.frm[2] = f2;
    v.bpf = bpf;  v.n_exp = n_exp;
    v.expf[0] = e0;  v.expf[1] = e1;  v.expf[2] = e2;
    v.abort_c = abort_c;  v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Run one burst; cycle c counts edges after the start edge (c=0 is POP).
  task automatic run_vec(input int id, input vec_t v);
    int   total, c_end, i;
    int   miso_err, pop_err, done_err, busy_err, abort_err;
    int   miso_bad, pop_bad, done_bad, busy_bad, abort_bad;
    logic live, e_miso, e_pop, e_done, e_busy, e_abort;
    total = v.n_exp * v.bpf;
    c_end = (v.abort_c < 0) ? total + 5 : v.abort_c + 4;
    miso_err = 0; pop_err = 0; done_err = 0; busy_err = 0; abort_err = 0;
    miso_bad = -1; pop_bad = -1; done_bad = -1; busy_bad = -1; abort_bad = -1;
    fifo_q.delete();
    for (int k = 0; k < v.n_fifo; k++) fifo_q.push_back(v.frm[k]);
    @(negedge SCK);
    CS_N = 1'b0; STREAM_EN = 1'b1; BURST_LEN = v.burst; WORD_MASK = v.mask;
    for (int c = 0; c < c_end; c++) begin
      @(negedge SCK);
      if (c == 0) begin
        STREAM_EN = 1'b0; BURST_LEN = ~v.burst; WORD_MASK = ~v.mask;
      end
      if (c == v.abort_c) CS_N = 1'b1;
      #2;
      live = (v.abort_c < 0) || (c <= v.abort_c);
      i = c - 2;
      e_miso = 1'b0;
      if (live && i >= 0 && i < total) e_miso = v.expf[i / v.bpf][127 - (i % v.bpf)];
      e_pop = live && (v.abort_c < 0 || c < v.abort_c) &&
              (c % v.bpf == 0) && (c / v.bpf < v.n_exp);
      e_done = live && (c >= 2 + v.bpf) && ((c - 2) % v.bpf == 0) &&
               ((c - 2) / v.bpf <= v.n_exp);
      e_busy = (v.abort_c < 0) ? (c < 2 + total) : (c <= v.abort_c);
      e_abort = (v.abort_c >= 0) && (c == v.abort_c + 1);
      if (MISO !== e_miso)       begin if (miso_err == 0)  miso_bad = c;  miso_err++;  end
      if (FIFO_POP !== e_pop)    begin if (pop_err == 0)   pop_bad = c;   pop_err++;   end
      if (FRAME_DONE !== e_done) begin if (done_err == 0)  done_bad = c;  done_err++;  end
      if (BUSY !== e_busy)       begin if (busy_err == 0)  busy_bad = c;  busy_err++;  end
      if (ABORT !== e_abort)     begin if (abort_err == 0) abort_bad = c; abort_err++; end
    end
    check($sformatf("v%0d miso bad bits (first at cycle %0d)", id, miso_bad), miso_err, 0);
    check($sformatf("v%0d fifo_pop bad cycles (first at %0d)", id, pop_bad), pop_err, 0);
    check($sformatf("v%0d frame_done bad cycles (first at %0d)", id, done_bad), done_err, 0);
    check($sformatf("v%0d busy bad cycles (first at %0d)", id, busy_bad), busy_err, 0);
    check($sformatf("v%0d abort bad cycles (first at %0d)", id, abort_bad), abort_err, 0);
    check($sformatf("v%0d frame_cnt", id), FRAME_CNT, v.exp_cnt);
    @(negedge SCK);
    CS_N = 1'b1; STREAM_EN = 1'b0;
    @(negedge SCK);
  endtask

  localparam logic [127:0] FA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] FB = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] FC = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] T1F = 128'h0001_0002_0003_0004_0005_0006_0007_0008;

  initial begin
    vecs[0] = mk(8'd1, 8'hFF, 1, T1F, '0, '0, 128, 1, T1F, '0, '0, -1, 8'd1);
    vecs[1] = mk(8'd3, 8'hFF, 3, FA, FB, FC, 128, 3, FA, FB, FC, -1, 8'd3);
    vecs[2] = mk(8'd2, 8'h81, 2,
                 128'hAAAA_1111_2222_3333_4444_5555_6666_5555,
                 128'h1234_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_ABCD, '0, 32, 2,
                 {32'hAAAA_5555, 96'h0}, {32'h1234_ABCD, 96'h0}, '0, -1, 8'd2);
    vecs[3] = mk(8'd1, 8'h00, 1, 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F, '0, '0,
                 128, 1, 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F, '0, '0, -1, 8'd1);
    vecs[4] = mk(8'd2, 8'h16, 2,
                 128'h7777_6666_5555_4444_3333_2222_1111_0000,
                 128'h1111_2222_3333_4444_5555_6666_7777_8888, '0, 48, 2,
                 {48'h4444_2222_1111, 80'h0}, {48'h4444_6666_7777, 80'h0}, '0, -1, 8'd2);
    vecs[5] = mk(8'd3, 8'h01, 3,
                 128'h1111_1111_1111_1111_1111_1111_1111_8001,
                 128'h2222_2222_2222_2222_2222_2222_2222_7FFE,
                 128'h3333_3333_3333_3333_3333_3333_3333_C3A5, 16, 3,
                 {16'h8001, 112'h0}, {16'h7FFE, 112'h0}, {16'hC3A5, 112'h0}, -1, 8'd3);
    vecs[6] = mk(8'd2, 8'hFF, 1, FA, '0, '0, 128, 2, FA, '0, '0, -1, 8'd2);
    vecs[7] = mk(8'd0, 8'hFF, 3, FA, FB, FC, 128, 3, FA, FB, FC, 200, 8'd1);
    vecs[8] = mk(8'd2, 8'h01, 2,
                 128'h0000_0000_0000_0000_0000_0000_0000_FFFF,
                 128'h0000_0000_0000_0000_0000_0000_0000_1234, '0, 16, 2,
                 {16'hFFFF, 112'h0}, {16'h1234, 112'h0}, '0, 16, 8'd0);

    // Reset state, with a start request held during reset
    CS_N = 1'b0; STREAM_EN = 1'b1; BURST_LEN = 8'd1; WORD_MASK = 8'hFF;
    repeat (3) @(negedge SCK);
    #2;
    check("reset busy", BUSY, 0);
    check("reset fifo_pop", FIFO_POP, 0);
    check("reset miso", MISO, 0);
    check("reset frame_done", FRAME_DONE, 0);
    check("reset abort", ABORT, 0);
    check("reset frame_cnt", FRAME_CNT, 0);
    @(negedge SCK);
    CS_N = 1'b1; STREAM_EN = 1'b0;
    @(negedge SCK);
    NRST_sync = 1'b1;
    repeat (2) @(negedge SCK);

    for (int v = 0; v < 9; v++) run_vec(v, vecs[v]);

    // Async reset in the middle of frame 2 of a two-frame burst
    fifo_q.delete();
    fifo_q.push_back(FA);
    fifo_q.push_back({128{1'b1}});
    @(negedge SCK);
    CS_N = 1'b0; STREAM_EN = 1'b1; BURST_LEN = 8'd2; WORD_MASK = 8'hFF;
    @(negedge SCK);
    STREAM_EN = 1'b0;
    repeat (150) @(negedge SCK);
    #2;
    check("pre-reset miso", MISO, 1);
    check("pre-reset frame_cnt", FRAME_CNT, 1);
    check("pre-reset busy", BUSY, 1);
    NRST_sync = 1'b0;
    #1;
    check("mid reset busy", BUSY, 0);
    check("mid reset miso", MISO, 0);
    check("mid reset fifo_pop", FIFO_POP, 0);
    check("mid reset frame_done", FRAME_DONE, 0);
    check("mid reset abort", ABORT, 0);
    check("mid reset frame_cnt", FRAME_CNT, 0);
    @(negedge SCK);
    CS_N = 1'b1;
    @(negedge SCK);
    NRST_sync = 1'b1;
    @(negedge SCK);
    run_vec(9, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
